// File: rtl/contador_pkg.sv
// contador_pkg
//   Shared definitions for the contador_mod_updown counter family.
//   - mode_e   : overflow behaviour at the range boundaries (wrap / saturate)
//   - DIR_UP / DIR_DOWN : encoding of the up_dn direction input
package contador_pkg;

   typedef enum logic {
      MODE_WRAP = 1'b0,
      MODE_SAT  = 1'b1
   } mode_e;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/contador_prescaler.sv
// contador_prescaler
//   Clock-enable divider for contador_mod_updown. A phase counter runs
//   0..PRESCALE-1, advancing only on enabled cycles; tick is high while the
//   phase sits at PRESCALE-1, so every PRESCALE-th enabled cycle steps the
//   counter. PRESCALE=1 keeps tick permanently high.
//
//   Ports:
//     clk    in  1  clock, rising edge
//     reset  in  1  synchronous, active-high reset (phase -> 0)
//     clr    in  1  synchronous phase clear (driven by the counter load strobe)
//     en     in  1  advance enable
//     tick   out 1  step qualifier, decoded from the registered phase
module contador_prescaler #(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] r_phase;

   // Decoded from a register only, so no input-to-output path exists.
   assign tick = (r_phase == LAST);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         r_phase <= '0;
      end else if (en) begin
         r_phase <= tick ? '0 : r_phase + PW'(1);
      end
   end

endmodule

// File: rtl/contador_mod_updown.sv
// contador_mod_updown
//   Modulo up/down counter over the range 0..MAX with synchronous load,
//   wrap or saturate behaviour at the boundaries, a one-cycle terminal-count
//   pulse and a sticky overflow flag.
//   Edge priority: reset > load > step > hold.
//
//   Optional feature: define CONTADOR_PRESCALER_EN to insert a clock-enable
//   prescaler (PRESCALE enabled cycles per step). Without it every enabled
//   cycle is a step and PRESCALE has no effect.
//
//   Ports:
//     clk       in  1  clock, rising edge
//     reset     in  1  synchronous, active-high reset
//     en        in  1  count enable
//     up_dn     in  1  direction (DIR_UP / DIR_DOWN)
//     mode      in  1  MODE_WRAP / MODE_SAT
//     load      in  1  synchronous load strobe (ignores en)
//     load_val  in  N  value to load, clamped to MAX
//     count     out N  registered count
//     tc        out 1  registered boundary-step pulse
//     ovf       out 1  registered sticky boundary flag, cleared by reset/load
module contador_mod_updown
   import contador_pkg::*;
#(
   parameter int N        = 8,
   parameter int MAX      = (2**N) - 1,
   parameter int PRESCALE = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         up_dn,
   input  logic         mode,
   input  logic         load,
   input  logic [N-1:0] load_val,
   output logic [N-1:0] count,
   output logic         tc,
   output logic         ovf
);

   localparam logic [N-1:0] MAX_V = N'(MAX);

   logic [N-1:0] r_count;
   logic         r_tc;
   logic         r_ovf;

   logic         w_tick;
   logic         w_step;
   logic         w_up;
   logic         w_at_bound;
   mode_e        w_mode;
   logic [N-1:0] w_load_clamped;
   logic [N-1:0] w_next;

`ifdef CONTADOR_PRESCALER_EN
   contador_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .clr   (load),
      .en    (en),
      .tick  (w_tick)
   );
`else
   logic w_unused_prescale;
   assign w_unused_prescale = ^PRESCALE;
   assign w_tick            = 1'b1;
`endif

   assign w_mode         = mode_e'(mode);
   assign w_up           = (up_dn == DIR_UP);
   assign w_step         = en & w_tick;
   assign w_at_bound     = w_up ? (r_count == MAX_V) : (r_count == '0);
   // Clamping here keeps any value above MAX from ever being registered.
   assign w_load_clamped = (load_val > MAX_V) ? MAX_V : load_val;

   always_comb begin
      w_next = r_count;
      if (w_at_bound) begin
         if (w_mode == MODE_WRAP) begin
            w_next = w_up ? '0 : MAX_V;
         end
      end else if (up_dn == DIR_DOWN) begin
         w_next = r_count - N'(1);
      end else begin
         w_next = r_count + N'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
         r_tc    <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (load) begin
         r_count <= w_load_clamped;
         r_tc    <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (w_step) begin
         r_count <= w_next;
         // A boundary step pulses tc in both modes, even when saturation
         // leaves the count unchanged.
         r_tc    <= w_at_bound;
         r_ovf   <= r_ovf | w_at_bound;
      end else begin
         r_tc    <= 1'b0;
      end
   end

   assign count = r_count;
   assign tc    = r_tc;
   assign ovf   = r_ovf;

endmodule

// File: tb/tb_contador_mod_updown.sv
// tb_contador_mod_updown
//   Bench for contador_mod_updown with N=4, MAX=9. Instance dut uses
//   PRESCALE=1, instance dut_p uses PRESCALE=3 (only distinct when
//   CONTADOR_PRESCALER_EN is defined). Both share the same input stimulus.
module tb_contador_mod_updown;

   localparam int N      = 4;
   localparam int MAX    = 9;
   localparam int P_SLOW = 3;
`ifdef CONTADOR_PRESCALER_EN
   localparam int P_EFF  = P_SLOW;
`else
   localparam int P_EFF  = 1;
`endif

   logic         clk;
   logic         reset;
   logic         en;
   logic         up_dn;
   logic         mode;
   logic         load;
   logic [N-1:0] load_val;
   logic [N-1:0] count,   count_p;
   logic         tc,      tc_p;
   logic         ovf,     ovf_p;

   int n_tests = 0;
   int n_fail  = 0;

   contador_mod_updown #(.N(N), .MAX(MAX), .PRESCALE(1)) dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .up_dn    (up_dn),
      .mode     (mode),
      .load     (load),
      .load_val (load_val),
      .count    (count),
      .tc       (tc),
      .ovf      (ovf)
   );

   contador_mod_updown #(.N(N), .MAX(MAX), .PRESCALE(P_SLOW)) dut_p (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .up_dn    (up_dn),
      .mode     (mode),
      .load     (load),
      .load_val (load_val),
      .count    (count_p),
      .tc       (tc_p),
      .ovf      (ovf_p)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- driver helpers ----------------
   task automatic drive(input logic r, input logic ld, input logic e,
                        input logic u, input logic m, input logic [N-1:0] lv);
      reset = r; load = ld; en = e; up_dn = u; mode = m; load_val = lv;
   endtask

   // Advance past one rising edge; outputs are sampled 1ns later.
   task automatic edge_step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Two independent models: index 0 tracks dut, index 1 tracks dut_p.
   int m_count[2];
   int m_phase[2];
   int m_tc[2];
   int m_ovf[2];

   task automatic model_edge(input int k, input int prescale);
      int  lv;
      bit  tick;
      lv = int'(load_val);
      if (reset) begin
         m_count[k] = 0; m_tc[k] = 0; m_ovf[k] = 0; m_phase[k] = 0;
      end else if (load) begin
         m_count[k] = (lv > MAX) ? MAX : lv;
         m_tc[k] = 0; m_ovf[k] = 0; m_phase[k] = 0;
      end else if (en) begin
         tick = (m_phase[k] == prescale - 1);
         m_phase[k] = tick ? 0 : m_phase[k] + 1;
         m_tc[k] = 0;
         if (tick) begin
            if (up_dn && m_count[k] == MAX) begin
               m_tc[k] = 1; m_ovf[k] = 1;
               m_count[k] = mode ? MAX : 0;
            end else if (!up_dn && m_count[k] == 0) begin
               m_tc[k] = 1; m_ovf[k] = 1;
               m_count[k] = mode ? 0 : MAX;
            end else begin
               m_count[k] = up_dn ? m_count[k] + 1 : m_count[k] - 1;
            end
         end
      end else begin
         m_tc[k] = 0;
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic         rst;
      logic         ld;
      logic         en;
      logic         up;
      logic         md;
      logic [N-1:0] lv;
      int           c;
      int           tc;
      int           ovf;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic ld, input logic e, input logic u,
                      input logic m, input int lv, input int c, input int t, input int o);
      vec_t v;
      v.rst = r; v.ld = ld; v.en = e; v.up = u; v.md = m; v.lv = N'(lv);
      v.c = c; v.tc = t; v.ovf = o;
      vecs.push_back(v);
   endtask

   initial begin
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);

      // --- table fill: rst ld en up md lv | count tc ovf ---
      add(1,0,0,1,0,0,  0,0,0);                         // reset state
      for (int i = 1; i <= 9; i++) add(0,0,1,1,0,0, i,0,0);
      add(0,0,1,1,0,0,  0,1,1);                         // 9 -> 0 wrap
      add(0,0,1,1,0,0,  1,0,1);                         // ovf sticky
      add(0,1,0,0,1,2,  2,0,0);                         // load clears ovf
      add(0,0,1,0,1,0,  1,0,0);
      add(0,0,1,0,1,0,  0,0,0);
      add(0,0,1,0,1,0,  0,1,1);                         // saturate at 0
      add(0,0,0,0,1,0,  0,0,1);                         // hold: no pulse
      add(0,0,1,0,1,0,  0,1,1);                         // each held step pulses
      add(0,0,1,0,0,0,  9,1,1);                         // mode switch to wrap
      add(0,0,1,0,0,0,  8,0,1);
      add(0,1,1,1,0,15, 9,0,0);                         // clamp, load beats en
      add(0,0,1,1,1,0,  9,1,1);                         // saturate at MAX
      add(0,0,1,1,0,0,  0,1,1);                         // wrap at MAX
      add(0,1,0,1,0,3,  3,0,0);
      add(0,0,1,1,0,0,  4,0,0);                         // en 1,0,1
      add(0,0,0,1,0,0,  4,0,0);
      add(0,0,1,1,0,0,  5,0,0);
      add(0,1,0,1,0,9,  9,0,0);
      add(0,0,1,1,0,0,  0,1,1);
      for (int i = 1; i <= 5; i++) add(0,0,1,1,0,0, i,0,1);
      add(1,1,1,1,0,7,  0,0,0);                         // reset beats load+en

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].ld, vecs[i].en, vecs[i].up, vecs[i].md, vecs[i].lv);
         edge_step();
         check($sformatf("vec%0d_count", i), int'(count), vecs[i].c);
         check($sformatf("vec%0d_tc", i),    int'(tc),    vecs[i].tc);
         check($sformatf("vec%0d_ovf", i),   int'(ovf),   vecs[i].ovf);
      end

      // --- hand sequence: prescaled instance from reset, counting up ---
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
      edge_step();
      check("pre_reset_count", int'(count_p), 0);
      begin
`ifdef CONTADOR_PRESCALER_EN
         int exp_seq[6] = '{0, 0, 1, 1, 1, 2};
`else
         int exp_seq[6] = '{1, 2, 3, 4, 5, 6};
`endif
         drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
         for (int i = 0; i < 6; i++) begin
            edge_step();
            check($sformatf("pre_run%0d", i), int'(count_p), exp_seq[i]);
         end
      end
      // One more enabled edge, then load in the middle of a phase.
      edge_step();
      drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd4);
      edge_step();
      check("pre_load_count", int'(count_p), 4);
      begin
`ifdef CONTADOR_PRESCALER_EN
         int exp_after[3] = '{4, 4, 5};
`else
         int exp_after[3] = '{5, 6, 7};
`endif
         drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
         for (int i = 0; i < 3; i++) begin
            edge_step();
            check($sformatf("pre_after_load%0d", i), int'(count_p), exp_after[i]);
            check($sformatf("pre_after_load_tc%0d", i), int'(tc_p), 0);
         end
      end

      // --- randomized run against the reference model ---
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
      edge_step();
      model_edge(0, 1);
      model_edge(1, P_EFF);
      for (int cyc = 0; cyc < 400; cyc++) begin
         drive(($urandom_range(0, 39) == 0),
               ($urandom_range(0, 9) == 0),
               ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 99) < ((cyc / 100) % 2 == 0 ? 80 : 20)),
               ($urandom_range(0, 1) == 1),
               N'($urandom_range(0, 15)));
         edge_step();
         model_edge(0, 1);
         model_edge(1, P_EFF);
         check("rnd_count",   int'(count),   m_count[0]);
         check("rnd_tc",      int'(tc),      m_tc[0]);
         check("rnd_ovf",     int'(ovf),     m_ovf[0]);
         check("rnd_p_count", int'(count_p), m_count[1]);
         check("rnd_p_tc",    int'(tc_p),    m_tc[1]);
         check("rnd_p_ovf",   int'(ovf_p),   m_ovf[1]);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/contador_mod_updown.md
# contador_mod_updown

Parametrised modulo up/down counter, the general-purpose successor to the team's free-running N-bit counter. Adds a programmable terminal value, direction control, synchronous load, wrap or saturate modes, a terminal-count pulse, a sticky overflow flag and an optional clock-enable prescaler. Used wherever lab designs need timebases, digit counters (BCD with MAX=9) or bounded event counters.

## Interface
- N, default 8: counter width in bits, N >= 2.
- MAX, default 2**N-1: top of count range; range is 0..MAX, MAX <= 2**N-1.
- PRESCALE, default 1: enable cycles per count step, >= 1; used only with the prescaler macro.
- clk  in  1  clock, rising edge.
- reset  in  1  reset, synchronous, active-high.
- en  in  1  count enable.
- up_dn  in  1  direction: 1 up, 0 down.
- mode  in  1  0 = wrap (MODE_WRAP), 1 = saturate (MODE_SAT).
- load  in  1  synchronous load strobe.
- load_val  in  N  value to load.
- count  out  N  current count, registered.
- tc  out  1  terminal-count pulse, one cycle.
- ovf  out  1  sticky boundary-crossing flag.

## Operation
- Priority per edge: reset > load > step > hold.
- reset: count=0, tc=0, ovf=0, prescaler phase=0.
- load: count <= min(load_val, MAX); tc=0; ovf cleared; prescaler phase cleared. Load ignores en.
- Step occurs when en=1 and prescaler tick=1.
- Up step: count<MAX -> count+1. count==MAX -> wrap mode 0, saturate mode stays MAX.
- Down step: count>0 -> count-1. count==0 -> wrap mode MAX, saturate mode stays 0.
- Boundary step (up at MAX or down at 0): tc=1 for that one cycle, ovf set, in both modes.
- tc=0 on all other cycles, including hold and non-boundary steps.
- ovf stays 1 until reset or load.
- Arithmetic in N bits; no intermediate value outside 0..MAX is ever registered. Count loaded or held above MAX is impossible by construction.
- Changing up_dn or mode mid-run takes effect on the next step; no state besides count/prescaler phase.
- en=0: count, prescaler phase held; tc=0; ovf held.

## Timing
- All outputs registered; step/load visible on count one cycle after the sampling edge.
- tc asserted in the same cycle the wrapped/saturated count appears.
- Reset mid-operation (including with load=1, en=1) wins on that edge.
- No combinational path from inputs to outputs.

## Configuration
- CONTADOR_PRESCALER_EN defined: prescaler instantiated; tick=1 on every PRESCALE-th enabled cycle (phase counter 0..PRESCALE-1, advances only when en=1, tick when phase==PRESCALE-1 then phase returns to 0). PRESCALE=1 gives tick every enabled cycle.
- Undefined: prescaler absent, tick tied to 1, PRESCALE ignored; counter steps on every en=1 cycle.

## Structure
- Package contador_pkg: typedef enum logic {MODE_WRAP, MODE_SAT} mode_e; constants DIR_UP=1, DIR_DOWN=0.
- Sub-module contador_prescaler (parameter PRESCALE; ports clk, reset, clr, en, tick), instantiated only under CONTADOR_PRESCALER_EN; clr driven by load.
- Top holds next-count logic and tc/ovf registers.

## Test plan
- N=4, MAX=9, wrap, up, en=1 from reset for 12 cycles -> count 0..9,0,1; tc=1 exactly at the 9->0 cycle; ovf=1 from then on.
- N=4, MAX=9, saturate, down from load_val=2 -> 2,1,0,0,0; tc=1 on first 0->0 step only per step cycle (each held step at 0 pulses tc); ovf=1.
- load_val=15 with MAX=9 -> count=9, tc=0, ovf cleared; same edge with en=1 -> load wins.
- reset=1 together with load=1, en=1 at count=5 -> count=0, tc=0, ovf=0 next cycle.
- en toggling 1,0,1 at count=3 up -> 4,4,5; tc stays 0.
- Macro defined, PRESCALE=3, en=1 up from 0 -> count increments every 3rd cycle (0,0,1,1,1,2...); load mid-phase restarts 3-cycle phase.
